// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared encodings for the program-counter sequencer: jump
//               source selects and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Next-PC source select (jmp_sel); codes 6 and 7 fall back to sequential.
    localparam logic [2:0] JMP_SEQ  = 3'd0;
    localparam logic [2:0] JMP_REG  = 3'd1;
    localparam logic [2:0] JMP_ABS  = 3'd2;
    localparam logic [2:0] JMP_REL  = 3'd3;
    localparam logic [2:0] JMP_CALL = 3'd4;
    localparam logic [2:0] JMP_RET  = 3'd5;

    // Sequencer phase encoding.
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. Pushing into a full stack
//               overwrites the oldest entry; popping an empty stack is a
//               no-op. Both corner cases raise a one-cycle strobe.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write push_data as the new top
//               pop             - discard the current top
//               top             - current top entry (valid when !empty)
//               empty, full     - occupancy status
//               ovf, unf        - push-while-full / pop-while-empty strobes
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;      // next slot to write
    logic [CNT_W-1:0] r_cnt;      // live entries, saturates at DEPTH
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_ptr_inc;

    // Top sits one slot behind the write pointer, wrapping at DEPTH
    // (DEPTH need not be a power of two).
    assign w_top_idx = (r_ptr == '0) ? c_last_idx : (r_ptr - c_ptr_one);
    assign w_ptr_inc = (r_ptr == c_last_idx) ? '0 : (r_ptr + c_ptr_one);

    assign top   = r_mem[w_top_idx];
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == c_full_cnt);
    assign ovf   = push && full;
    assign unf   = pop && !push && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            // When full, the write slot holds the oldest entry, so the
            // overwrite drops it and the count stays saturated.
            r_mem[r_ptr] <= push_data;
            r_ptr        <= w_ptr_inc;
            if (!full) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end else if (pop && !empty) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program-counter sequencer. LOAD phase steps the
//               instruction-memory download address; RUN phase selects the
//               next PC from sequential, register, absolute, PC-relative,
//               call and return sources, with fetch stall, branch-condition
//               gate and a return-address stack.
// Ports       : clk, rst                        - clock, sync active-high reset
//               load_start, load_count          - begin a download of N words
//               load_valid, load_addr, load_busy- download beat handshake
//               stall, jmp_sel, cond_ok         - RUN-phase control
//               rs, abs_add, rel_add            - jump target operands
//               pc_out, fetch_en                - current fetch PC / enable
//               ret_addr                        - link value of last CALL
//               ras_ovf, ras_unf                - sticky stack error flags
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                PC_W      = 32,
    parameter int                ABS_W     = 26,
    parameter int                REL_W     = 21,
    parameter int                RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]   RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [PC_W-1:0]   load_count,
    input  logic              load_valid,
    output logic [PC_W-1:0]   load_addr,
    output logic              load_busy,
    input  logic              stall,
    input  logic [2:0]        jmp_sel,
    input  logic              cond_ok,
    input  logic [PC_W-1:0]   rs,
    input  logic [ABS_W-1:0]  abs_add,
    input  logic [REL_W-1:0]  rel_add,
    output logic [PC_W-1:0]   pc_out,
    output logic              fetch_en,
    output logic [PC_W-1:0]   ret_addr,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [PC_W-1:0] c_one = PC_W'(1);

    logic [ST_W-1:0] r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_load_addr;
    logic [PC_W-1:0] r_remaining;
    logic [PC_W-1:0] r_ret_addr;
    logic            r_ras_ovf;
    logic            r_ras_unf;

    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_abs_tgt;
    logic [PC_W-1:0] w_rel_sext;
    logic [PC_W-1:0] w_next_pc;
    logic [2:0]      w_eff_sel;
    logic            w_active;
    logic            w_do_call;
    logic            w_do_ret;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_ras_ovf;
    logic            w_ras_unf;

    // ------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------
    assign w_inc      = r_pc + c_one;
    assign w_abs_tgt  = {w_inc[PC_W-1:ABS_W], abs_add};
    assign w_rel_sext = {{(PC_W-REL_W){rel_add[REL_W-1]}}, rel_add};

    // A failed condition degrades every redirect, including CALL/RET,
    // to a plain sequential step so the stack is never touched.
    assign w_eff_sel = cond_ok ? jmp_sel : JMP_SEQ;
    assign w_active  = (r_state == ST_RUN) && !stall;
    assign w_do_call = w_active && (w_eff_sel == JMP_CALL);
    assign w_do_ret  = w_active && (w_eff_sel == JMP_RET);

    always_comb begin
        w_next_pc = w_inc;
        case (w_eff_sel)
            JMP_REG:           w_next_pc = rs;
            JMP_ABS, JMP_CALL: w_next_pc = w_abs_tgt;
            JMP_REL:           w_next_pc = w_inc + w_rel_sext;
            JMP_RET:           w_next_pc = w_ras_empty ? w_inc : w_ras_top;
            default:           w_next_pc = w_inc;
        endcase
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_do_call),
        .push_data (w_inc),
        .pop       (w_do_ret),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full),
        .ovf       (w_ras_ovf),
        .unf       (w_ras_unf)
    );

    // ------------------------------------------------------------------
    // Phase FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VEC;
            r_load_addr <= '0;
            r_remaining <= '0;
            r_ret_addr  <= '0;
            r_ras_ovf   <= 1'b0;
            r_ras_unf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        if (load_count == '0) begin
                            r_state <= ST_RUN;
                            r_pc    <= RESET_VEC;
                        end else begin
                            r_state     <= ST_LOAD;
                            r_remaining <= load_count;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        r_load_addr <= r_load_addr + c_one;
                        r_remaining <= r_remaining - c_one;
                        if (r_remaining == c_one) begin
                            r_state <= ST_RUN;
                            r_pc    <= RESET_VEC;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        r_pc <= w_next_pc;
                        if (w_do_call) begin
                            r_ret_addr <= w_inc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_ras_ovf) begin
                r_ras_ovf <= 1'b1;
            end
            if (w_ras_unf) begin
                r_ras_unf <= 1'b1;
            end
        end
    end

    assign pc_out    = r_pc;
    assign load_addr = r_load_addr;
    assign load_busy = (r_state == ST_LOAD);
    // Stall must gate fetch in the same cycle, so it bypasses the register.
    assign fetch_en  = (r_state == ST_RUN) && !stall;
    assign ret_addr  = r_ret_addr;
    assign ras_ovf   = r_ras_ovf;
    assign ras_unf   = r_ras_unf;

    // w_ras_full is kept for observability of the stack occupancy.
    logic w_unused;
    assign w_unused = w_ras_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer: reset, LOAD
//               stepping, RUN next-PC sources, branch gate, return-address
//               stack overflow/underflow, stall hold, mid-LOAD reset and
//               zero-length download.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W  = 32;
    localparam int ABS_W = 26;
    localparam int REL_W = 21;

    logic              clk;
    logic              rst;
    logic              load_start;
    logic [PC_W-1:0]   load_count;
    logic              load_valid;
    logic [PC_W-1:0]   load_addr;
    logic              load_busy;
    logic              stall;
    logic [2:0]        jmp_sel;
    logic              cond_ok;
    logic [PC_W-1:0]   rs;
    logic [ABS_W-1:0]  abs_add;
    logic [REL_W-1:0]  rel_add;
    logic [PC_W-1:0]   pc_out;
    logic              fetch_en;
    logic [PC_W-1:0]   ret_addr;
    logic              ras_ovf;
    logic              ras_unf;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(
        .PC_W      (PC_W),
        .ABS_W     (ABS_W),
        .REL_W     (REL_W),
        .RAS_DEPTH (4),
        .RESET_VEC (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_count (load_count),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_busy  (load_busy),
        .stall      (stall),
        .jmp_sel    (jmp_sel),
        .cond_ok    (cond_ok),
        .rs         (rs),
        .abs_add    (abs_add),
        .rel_add    (rel_add),
        .pc_out     (pc_out),
        .fetch_en   (fetch_en),
        .ret_addr   (ret_addr),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic jump(input logic [2:0] sel);
        jmp_sel = sel;
        tick();
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_count = '0; load_valid = 1'b0;
        stall = 1'b0; jmp_sel = 3'd0; cond_ok = 1'b1;
        rs = '0; abs_add = '0; rel_add = '0;

        // ---- reset ----
        tick(); tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_fetch_en", {31'b0, fetch_en}, 32'h0);
        chk("rst_load_busy", {31'b0, load_busy}, 32'h0);
        chk("rst_ovf", {31'b0, ras_ovf}, 32'h0);
        chk("rst_unf", {31'b0, ras_unf}, 32'h0);
        chk("rst_load_addr", load_addr, 32'h0);
        chk("rst_ret_addr", ret_addr, 32'h0);
        rst = 1'b0;

        // ---- download of 3 words, beats on cycles 1,3,4 ----
        load_start = 1'b1; load_count = 32'd3; tick();
        load_start = 1'b0;
        chk("load_busy_enter", {31'b0, load_busy}, 32'h1);
        chk("load_addr_0", load_addr, 32'h0);
        load_valid = 1'b1; tick();
        chk("load_addr_1", load_addr, 32'h1);
        load_valid = 1'b0; tick();
        chk("load_addr_hold", load_addr, 32'h1);
        chk("load_busy_gap", {31'b0, load_busy}, 32'h1);
        load_valid = 1'b1; tick();
        chk("load_addr_2", load_addr, 32'h2);
        chk("load_busy_2", {31'b0, load_busy}, 32'h1);
        tick();
        load_valid = 1'b0;
        chk("load_addr_3", load_addr, 32'h3);
        chk("load_busy_done", {31'b0, load_busy}, 32'h0);
        chk("run_pc", pc_out, 32'h0);
        chk("run_fetch_en", {31'b0, fetch_en}, 32'h1);

        // load_start ignored in RUN
        load_start = 1'b1; load_count = 32'd5; jump(3'd0);
        load_start = 1'b0;
        chk("run_ignore_start", {31'b0, load_busy}, 32'h0);
        chk("seq_pc1", pc_out, 32'h1);

        // ---- REL / ABS / REG ----
        rs = 32'd10; jump(3'd1);
        chk("reg_10", pc_out, 32'd10);
        rel_add = 21'h1FFFFD; jump(3'd3);             // -3 relative to 11
        chk("rel_neg3", pc_out, 32'd8);
        abs_add = 26'h40; jump(3'd2);
        chk("abs_40", pc_out, 32'h40);
        rs = 32'h1234; jump(3'd1);
        chk("reg_1234", pc_out, 32'h1234);
        rs = 32'h0C00_0005; jump(3'd1);
        abs_add = 26'h7; jump(3'd2);                  // upper 6 bits kept from pc+1
        chk("abs_upper", pc_out, 32'h0C00_0007);
        rel_add = 21'h000010; jump(3'd3);
        chk("rel_pos", pc_out, 32'h0C00_0018);
        rs = 32'hFFFF_FFFF; jump(3'd1);
        jump(3'd7);                                   // unused code acts as SEQ, wraps
        chk("seq_wrap", pc_out, 32'h0);

        // ---- branch gate ----
        rs = 32'd5; jump(3'd1);
        cond_ok = 1'b0; rs = 32'h999; jump(3'd1);
        chk("gate_reg", pc_out, 32'd6);
        jump(3'd5);
        chk("gate_ret_pc", pc_out, 32'd7);
        chk("gate_ret_unf", {31'b0, ras_unf}, 32'h0);
        abs_add = 26'h300; jump(3'd4);
        chk("gate_call_pc", pc_out, 32'd8);
        chk("gate_call_ret", ret_addr, 32'h0);
        cond_ok = 1'b1;

        // ---- CALL chain overflowing a 4-deep stack ----
        rs = 32'd1; jump(3'd1);
        abs_add = 26'd11; jump(3'd4);
        chk("call1_pc", pc_out, 32'd11);
        chk("call1_ret", ret_addr, 32'd2);
        abs_add = 26'd21; jump(3'd4);
        abs_add = 26'd31; jump(3'd4);
        abs_add = 26'd41; jump(3'd4);
        chk("call4_ret", ret_addr, 32'd32);
        chk("call4_no_ovf", {31'b0, ras_ovf}, 32'h0);
        abs_add = 26'h100; jump(3'd4);
        chk("call5_pc", pc_out, 32'h100);
        chk("call5_ret", ret_addr, 32'd42);
        chk("call5_ovf", {31'b0, ras_ovf}, 32'h1);

        // ---- stall holds everything, including a pending CALL ----
        stall = 1'b1; abs_add = 26'h55; jmp_sel = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_out, 32'h100);
            chk("stall_ret", ret_addr, 32'd42);
            chk("stall_fetch_en", {31'b0, fetch_en}, 32'h0);
        end
        stall = 1'b0;

        // ---- returns: 42,32,22,12 then underflow ----
        jump(3'd5); chk("ret1", pc_out, 32'd42);
        jump(3'd5); chk("ret2", pc_out, 32'd32);
        jump(3'd5); chk("ret3", pc_out, 32'd22);
        jump(3'd5); chk("ret4", pc_out, 32'd12);
        chk("ret4_no_unf", {31'b0, ras_unf}, 32'h0);
        jump(3'd5); chk("ret5_pc", pc_out, 32'd13);
        chk("ret5_unf", {31'b0, ras_unf}, 32'h1);
        chk("ovf_sticky", {31'b0, ras_ovf}, 32'h1);

        // ---- reset mid-LOAD ----
        jmp_sel = 3'd0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_unf", {31'b0, ras_unf}, 32'h0);
        chk("rst2_pc", pc_out, 32'h0);
        load_start = 1'b1; load_count = 32'd4; tick();
        load_start = 1'b0; load_valid = 1'b1;
        tick(); tick();
        load_valid = 1'b0;
        chk("midload_addr", load_addr, 32'h2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midload_rst_busy", {31'b0, load_busy}, 32'h0);
        chk("midload_rst_addr", load_addr, 32'h0);
        chk("midload_rst_fetch", {31'b0, fetch_en}, 32'h0);
        tick();
        chk("idle_stays", {31'b0, fetch_en}, 32'h0);

        // ---- zero-length download goes straight to RUN ----
        load_start = 1'b1; load_count = 32'd0; tick();
        load_start = 1'b0;
        chk("zero_busy", {31'b0, load_busy}, 32'h0);
        chk("zero_fetch_en", {31'b0, fetch_en}, 32'h1);
        chk("zero_pc", pc_out, 32'h0);
        jump(3'd0);
        chk("zero_seq", pc_out, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
